rr_arbiter16: RTL
=================

# rr_arbiter16

Sixteen-requester round-robin arbiter with grant locking and an optional hold-time limit. It owns a single shared resource and outputs a one-hot grant plus its 4-bit index. The index is produced by instantiating `encoder16to4` on the registered one-hot grant. It sits between the requesting units and the resource's select/mux logic.

## Interface

- `HOLD_MAX`, default 16: maximum consecutive cycles one grant may be held while another request is pending. 0 disables the limit. Range 0..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset; see reset values below.
- `req` input 16: request vector, bit i = requester i; level-sensitive.
- `gnt` output 16: registered one-hot grant; all zero when no grant.
- `gnt_idx` output 4: index of the set `gnt` bit via `encoder16to4`; 0 when `gnt` is 0.
- `gnt_valid` output 1: registered; high exactly when `gnt` is non-zero.
- `gnt_expired` output 1: registered one-cycle pulse; marks a grant removed by the `HOLD_MAX` limit.

## Operation

- **Reset values:** `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `gnt_expired`=0. Internally, state=IDLE, round-robin pointer `ptr`=0, hold counter `hcnt`=0.
- **State machine:** two states, IDLE and GRANT.
- **IDLE:**
  - `gnt`=0.
  - If `req` is non-zero at a clock edge, select the first set bit scanning upward from `ptr` with wrap 15→0.
  - Load `gnt` with that bit, set `ptr`=(winner+1) mod 16, clear `hcnt`, and go to GRANT.
  - If `req`=0, remain in IDLE and leave `ptr` unchanged.
- **GRANT:**
  - `gnt` is held constant. `hcnt` increments each cycle and saturates at 255.
  - **Normal release:** at an edge where `req[winner]`=0, go to IDLE with `gnt`=0 and `gnt_expired`=0.
  - **Forced release:** at an edge where `HOLD_MAX`≠0, `hcnt`≥`HOLD_MAX`−1, and any other `req` bit is 1, go to IDLE with `gnt`=0 and `gnt_expired`=1 for one cycle.
  - **Both conditions at the same edge:** normal release wins and `gnt_expired`=0.
  - **No other request pending:** the holder keeps the grant indefinitely, even past `HOLD_MAX`.
- **Boundary rules:**
  - **Fairness:** `ptr` advances past the winner, so a requester that keeps requesting after release is the last candidate in the next scan.
  - **Pointer wrap:** when the winner is 15, `ptr` becomes 0.
  - **Invariant:** `gnt` is never multi-hot; `gnt_valid` is the OR-reduction of `gnt`, registered consistently with it.
  - **Request timing:** requests arriving or dropping during GRANT do not affect the current grant except through the release rules above.
  - **Mid-operation reset:** `reset_n` low in any state forces all reset values immediately, independent of `clk`. After deassertion, the first arbitration scans from bit 0.

## Timing

- **Grant latency:** a request sampled at edge N in IDLE gives `gnt` high after edge N; first usable cycle N+1.
- **Release latency:** `req[winner]` low sampled at edge M gives `gnt`=0 after edge M.
- **Minimum gap:** at least one cycle with `gnt`=0 between consecutive grants, so the next grant is asserted after edge M+1 at the earliest.
- **Forced-release cadence:** with `HOLD_MAX`=H and a competitor waiting, the holder keeps `gnt` for exactly H cycles. `gnt_expired` is then high for the one following cycle, in which `gnt`=0.
- **`gnt_idx` path:** purely combinational from registered `gnt`; no additional latency.

## Test plan

- **Reset:** `reset_n`=0 with `req`=16'hFFFF → `gnt`=0, `gnt_idx`=0, `gnt_valid`=0. Release reset → `gnt`=16'h0001, `gnt_idx`=0 one edge later.
- **Rotation:** hold `req`=16'h8001, with each holder dropping its request for one cycle after 2 cycles of grant → grants alternate 0,15,0,15. `gnt_idx` is 0/15 and there is a one-cycle zero gap between grants.
- **Wrap:** grant 15 with `req`=16'h8004. Release bit 15 → next `gnt`=16'h0004 (scan wraps to 0, first set bit is 2).
- **Hold limit:** `HOLD_MAX`=4, `req`=16'h0003 held continuously → requester 0 granted for 4 cycles. Then `gnt_expired`=1 for one cycle, then requester 1 is granted for 4 cycles, repeating.
- **No competitor:** `HOLD_MAX`=4, `req`=16'h0010 for 20 cycles → `gnt`=16'h0010 continuously and `gnt_expired` never asserts.
- **Simultaneous events and mid-grant reset:** with `HOLD_MAX`=2, drop `req[winner]` at the same edge the limit fires → `gnt_expired`=0. Assert `reset_n`=0 mid-grant → outputs go to 0 asynchronously and `ptr` restarts at 0.

Source files
------------

// File: rtl/rr_arbiter16.sv
// Sixteen-requester round-robin arbiter with grant locking and an optional hold-time limit.
// The grant index comes from a one-hot encoder fed by the registered grant.

module encoder16to4 (
    input  logic [15:0] i_onehot,
    output logic [3:0]  o_idx
);
    logic [15:0] w_terms [4];

    // Index bit gi is the OR of every one-hot bit whose position has bit gi set.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        for (genvar gj = 0; gj < 16; gj++) begin : g_term
            if (((gj >> gi) & 1) == 1) begin : g_on
                assign w_terms[gi][gj] = i_onehot[gj];
            end else begin : g_off
                assign w_terms[gi][gj] = 1'b0;
            end
        end
        assign o_idx[gi] = |w_terms[gi];
    end
endmodule

module rr_arbiter16 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        gnt_expired
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [8:0] HOLD_M1 = (HOLD_MAX == 0) ? 9'd0 : 9'(HOLD_MAX - 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_ptr, w_ptr_next;
    logic [7:0]  r_hcnt, w_hcnt_next;
    logic [15:0] r_gnt, w_gnt_next;
    logic        r_valid, w_valid_next;
    logic        r_expired, w_expired_next;

    logic [31:0] w_req_dbl;
    logic [15:0] w_req_rot;
    logic [3:0]  w_off;
    logic [3:0]  w_win;
    logic [15:0] w_win_oh;
    logic        w_hold_req;
    logic        w_others;
    logic        w_limit;

    // Rotate so the pointer position sits at bit 0; the lowest set bit is the winner offset.
    assign w_req_dbl = {req, req};
    assign w_req_rot = w_req_dbl[r_ptr +: 16];

    always_comb begin
        w_off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = 4'(i);
            end
        end
    end

    assign w_win      = r_ptr + w_off;
    assign w_win_oh   = 16'd1 << w_win;
    assign w_hold_req = |(req & r_gnt);
    assign w_others   = |(req & ~r_gnt);
    assign w_limit    = (HOLD_MAX != 0) && ({1'b0, r_hcnt} >= HOLD_M1);

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_hcnt_next    = r_hcnt;
        w_gnt_next     = r_gnt;
        w_valid_next   = r_valid;
        w_expired_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt_next   = 16'd0;
                w_valid_next = 1'b0;
                if (|req) begin
                    w_gnt_next   = w_win_oh;
                    w_valid_next = 1'b1;
                    w_ptr_next   = w_win + 4'd1;
                    w_hcnt_next  = 8'd0;
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (r_hcnt != 8'hFF) begin
                    w_hcnt_next = r_hcnt + 8'd1;
                end
                // Normal release takes precedence over the hold limit.
                if (!w_hold_req) begin
                    w_gnt_next   = 16'd0;
                    w_valid_next = 1'b0;
                    w_state_next = S_IDLE;
                end else if (w_limit && w_others) begin
                    w_gnt_next     = 16'd0;
                    w_valid_next   = 1'b0;
                    w_expired_next = 1'b1;
                    w_state_next   = S_IDLE;
                end
            end
            default: begin
                w_gnt_next   = 16'd0;
                w_valid_next = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 4'd0;
            r_hcnt    <= 8'd0;
            r_gnt     <= 16'd0;
            r_valid   <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_hcnt    <= w_hcnt_next;
            r_gnt     <= w_gnt_next;
            r_valid   <= w_valid_next;
            r_expired <= w_expired_next;
        end
    end

    encoder16to4 u_enc (
        .i_onehot (r_gnt),
        .o_idx    (gnt_idx)
    );

    assign gnt         = r_gnt;
    assign gnt_valid   = r_valid;
    assign gnt_expired = r_expired;
endmodule
